// File: rtl/hybrid_pkg.sv
// Shared definitions for the Hybrid reciprocal / sqrt / isqrt datapath and its BIST sequencer.
//   FUNC_*        : datapath function-select codes
//   bist_state_e  : BIST sequencer state encoding
package hybrid_pkg;

  localparam logic [1:0] FUNC_REC  = 2'b00;
  localparam logic [1:0] FUNC_SQRT = 2'b01;
  localparam logic [1:0] FUNC_ISQT = 2'b11;
  localparam logic [1:0] FUNC_RSVD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } bist_state_e;

endpackage

// File: rtl/hybrid_bist_if.sv
// Bundle of the BIST control/status, vector-ROM and datapath signals.
//   slave  : seen by hybrid_bist (control and ROM/datapath data in, status and drive out)
//   master : seen by the environment (controller, ROM and Hybrid unit)
interface hybrid_bist_if #(
  parameter int unsigned WL     = 25,
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic [1:0]        func_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic [WL-1:0]     rom_vec;
  logic [WL-1:0]     rom_exp;
  logic              dut_CE;
  logic [WL-1:0]     dut_din;
  logic [1:0]        dut_FUNCTION;
  logic [WL-1:0]     dut_dout;
  logic              busy;
  logic              done;
  logic              pass;
  logic              cfg_err;
  logic [ADDR_W:0]   mismatch_cnt;
  logic [ADDR_W-1:0] first_fail_idx;
  logic              first_fail_vld;

  modport slave (
    input  start, func_sel, rom_vec, rom_exp, dut_dout,
    output rom_addr, dut_CE, dut_din, dut_FUNCTION, busy, done, pass, cfg_err,
           mismatch_cnt, first_fail_idx, first_fail_vld
  );

  modport master (
    output start, func_sel, rom_vec, rom_exp, dut_dout,
    input  rom_addr, dut_CE, dut_din, dut_FUNCTION, busy, done, pass, cfg_err,
           mismatch_cnt, first_fail_idx, first_fail_vld
  );
endinterface

// File: rtl/hybrid_bist_dly.sv
// Fixed-latency shift line carrying {valid, expected, index} alongside the datapath pipeline.
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset, clears every stage
//   i_d  : word entering the line
//   o_q  : word delayed by LAT cycles
module hybrid_bist_dly #(
  parameter int unsigned LAT = 1,
  parameter int unsigned W   = 36
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [LAT];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned k = 0; k < LAT; k++) r_sr[k] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int unsigned k = 1; k < LAT; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  assign o_q = r_sr[LAT-1];

endmodule

// File: rtl/hybrid_bist.sv
// BIST sequencer: streams ROM vectors into the Hybrid unit one per cycle and checks each result
// against the expected value stored in the same ROM word.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset; aborts a run without a done pulse
//   bus : start/func_sel in; rom_addr out, rom_vec/rom_exp in; dut_CE/dut_din/dut_FUNCTION out,
//         dut_dout in; busy/done/pass/cfg_err/mismatch_cnt/first_fail_idx/first_fail_vld out
module hybrid_bist
  import hybrid_pkg::*;
#(
  parameter int unsigned WL      = 25,
  parameter int unsigned DEPTH   = 836,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LAT     = 1,
  parameter int unsigned IGN_LSB = 0
) (
  input logic           CLK,
  input logic           RST,
  hybrid_bist_if.slave  bus
);

  localparam int unsigned   DlyW    = 1 + WL + ADDR_W;
  localparam logic [WL-1:0] CmpMask = {WL{1'b1}} << IGN_LSB;

  bist_state_e       r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_drain;
  logic              r_busy;
  logic [1:0]        r_fn;
  logic              r_done;
  logic              r_pass;
  logic              r_cfg_err;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W-1:0] r_ff_idx;
  logic              r_ff_vld;
  // Tag for the ROM word arriving this cycle (read issued last cycle from a RUN address).
  logic              r_rd_vld;
  logic [ADDR_W-1:0] r_rd_idx;

  logic [DlyW-1:0]   w_dly;
  logic              w_vld;
  logic [WL-1:0]     w_exp;
  logic [ADDR_W-1:0] w_idx;
  logic              w_miss;
  logic [ADDR_W:0]   w_cnt_nxt;

  hybrid_bist_dly #(
    .LAT (LAT),
    .W   (DlyW)
  ) u_dly (
    .CLK (CLK),
    .RST (RST),
    .i_d ({r_rd_vld, bus.rom_exp, r_rd_idx}),
    .o_q (w_dly)
  );

  assign w_vld     = w_dly[DlyW-1];
  assign w_exp     = w_dly[ADDR_W +: WL];
  assign w_idx     = w_dly[ADDR_W-1:0];
  assign w_miss    = w_vld && (((bus.dut_dout ^ w_exp) & CmpMask) != '0);
  assign w_cnt_nxt = w_miss ? r_cnt + (ADDR_W+1)'(1) : r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_drain   <= '0;
      r_busy    <= 1'b0;
      r_fn      <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_cnt     <= '0;
      r_ff_idx  <= '0;
      r_ff_vld  <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_idx  <= '0;
    end else begin
      r_done   <= 1'b0;
      r_rd_vld <= (r_state == StRun);
      r_rd_idx <= r_addr;
      r_cnt    <= w_cnt_nxt;
      if (w_miss && !r_ff_vld) begin
        r_ff_idx <= w_idx;
        r_ff_vld <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_cnt    <= '0;
            r_ff_vld <= 1'b0;
            r_pass   <= 1'b0;
            r_addr   <= '0;
            if (bus.func_sel == FUNC_RSVD) begin
              // Reserved code: report straight away, never touch ROM or datapath.
              r_cfg_err <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= StDone;
            end else begin
              r_cfg_err <= 1'b0;
              r_fn      <= bus.func_sel;
              r_busy    <= 1'b1;
              r_state   <= StRun;
            end
          end
        end
        StRun: begin
          if (r_addr == ADDR_W'(DEPTH - 1)) begin
            r_drain <= '0;
            r_state <= StDrain;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        StDrain: begin
          // LAT+1 cycles: covers the ROM read stage plus the datapath latency.
          if (r_drain == 4'(LAT)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_cnt_nxt == '0) && !r_cfg_err;
            r_addr  <= '0;
            r_state <= StDone;
          end else begin
            r_drain <= r_drain + 4'd1;
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.rom_addr       = r_addr;
  assign bus.dut_CE         = r_busy;
  assign bus.dut_din        = bus.rom_vec;
  assign bus.dut_FUNCTION   = r_fn;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.cfg_err        = r_cfg_err;
  assign bus.mismatch_cnt   = r_cnt;
  assign bus.first_fail_idx = r_ff_idx;
  assign bus.first_fail_vld = r_ff_vld;

endmodule

// File: tb/tb_hybrid_bist.sv
// Directed bench for hybrid_bist. Three instances share one clock:
//   0: DEPTH=8,   LAT=1, IGN_LSB=0
//   1: DEPTH=8,   LAT=1, IGN_LSB=1
//   2: DEPTH=836, LAT=3, IGN_LSB=0
// Each has a synchronous ROM and a behavioural datapath model with optional fault injection.
module tb_hybrid_bist;

  localparam int unsigned WL = 25;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] r_start = '0;
  logic [2:0] r_rst   = '1;
  logic [1:0] r_func  [3];
  int         r_fault [3];

  logic [2:0]    w_done, w_ce, w_pass, w_cfg, w_ffvld, w_any;
  logic [AW-1:0] w_addr  [3];
  logic [1:0]    w_fn    [3];
  logic [AW:0]   w_cnt   [3];
  logic [AW-1:0] w_ffidx [3];

  int n_cmp = 0;
  int n_bad = 0;
  int d_cyc [3], d_num [3], ce_cnt [3], addr_err [3], fn_err [3], zero_err [3];

  function automatic logic [WL-1:0] vec_of(input int unsigned a);
    return WL'(a * 1237 + 11);
  endfunction

  function automatic logic [WL-1:0] model_f(input logic [WL-1:0] x, input logic [1:0] fn);
    logic [WL-1:0] t;
    t = x * WL'(3);
    t = t ^ {fn, 6'h2a, 17'h0};
    return t + WL'(fn);
  endfunction

  // Fault 1 corrupts vectors 3 and 6, fault 2 corrupts every result.
  function automatic logic [WL-1:0] flip_of(input int f, input logic [WL-1:0] din);
    if (f == 2 || (f == 1 && (din == vec_of(3) || din == vec_of(6)))) return WL'(1);
    return '0;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned GD = (g == 2) ? 836 : 8;
    localparam int unsigned GL = (g == 2) ? 3 : 1;
    localparam int unsigned GI = (g == 1) ? 1 : 0;

    hybrid_bist_if #(.WL(WL), .ADDR_W(AW)) bus ();
    logic [WL-1:0] m_pipe [GL];

    hybrid_bist #(
      .WL      (WL),
      .DEPTH   (GD),
      .ADDR_W  (AW),
      .LAT     (GL),
      .IGN_LSB (GI)
    ) u_dut (
      .CLK (clk),
      .RST (r_rst[g]),
      .bus (bus)
    );

    assign bus.start    = r_start[g];
    assign bus.func_sel = r_func[g];

    always_ff @(posedge clk) begin
      bus.rom_vec <= vec_of(32'(bus.rom_addr));
      bus.rom_exp <= model_f(vec_of(32'(bus.rom_addr)), r_func[g]);
    end

    always_ff @(posedge clk) begin
      if (bus.dut_CE) begin
        m_pipe[0] <= model_f(bus.dut_din, bus.dut_FUNCTION) ^ flip_of(r_fault[g], bus.dut_din);
        for (int k = 1; k < int'(GL); k++) m_pipe[k] <= m_pipe[k-1];
      end
    end
    assign bus.dut_dout = m_pipe[GL-1];

    assign w_done[g]  = bus.done;
    assign w_ce[g]    = bus.dut_CE;
    assign w_pass[g]  = bus.pass;
    assign w_cfg[g]   = bus.cfg_err;
    assign w_ffvld[g] = bus.first_fail_vld;
    assign w_addr[g]  = bus.rom_addr;
    assign w_fn[g]    = bus.dut_FUNCTION;
    assign w_cnt[g]   = bus.mismatch_cnt;
    assign w_ffidx[g] = bus.first_fail_idx;
    assign w_any[g]   = (|bus.rom_addr) | bus.dut_CE | (|bus.dut_FUNCTION) | bus.busy |
                        bus.done | bus.pass | bus.cfg_err | (|bus.mismatch_cnt) |
                        (|bus.first_fail_idx) | bus.first_fail_vld;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int g, input int cyc);
    int dep;
    dep = (g == 2) ? 836 : 8;
    return (cyc - 1 < dep - 1) ? cyc - 1 : dep - 1;
  endfunction

  // Starts a run on the masked instances (start accepted at the edge ending cycle 0) and
  // observes cycles 1..max_cyc. Optional extra start pulses and a reset cycle (0 = none).
  task automatic run(input logic [2:0] mask, input logic [1:0] fn, input int max_cyc,
                     input int pulse_a, input int pulse_b, input int rst_cyc);
    for (int g = 0; g < 3; g++) begin
      d_cyc[g] = 0; d_num[g] = 0; ce_cnt[g] = 0;
      addr_err[g] = 0; fn_err[g] = 0; zero_err[g] = 0;
      if (mask[g]) begin
        r_func[g]  = fn;
        r_start[g] = 1'b1;
      end
    end
    @(negedge clk);
    r_start = '0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      for (int g = 0; g < 3; g++) begin
        if (mask[g]) begin
          if (w_done[g]) begin
            d_num[g]++;
            if (d_cyc[g] == 0) d_cyc[g] = cyc;
          end
          if (w_ce[g]) begin
            ce_cnt[g]++;
            if (int'(w_addr[g]) != exp_addr(g, cyc)) addr_err[g]++;
            if (w_fn[g] != fn) fn_err[g]++;
          end
          if (rst_cyc > 0 && cyc == rst_cyc + 1 && w_any[g]) zero_err[g]++;
          r_start[g] = (cyc == pulse_a || cyc == pulse_b);
          r_rst[g]   = (rst_cyc > 0 && cyc == rst_cyc);
        end
      end
      @(negedge clk);
    end
    r_start = '0;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      r_func[g]  = 2'b00;
      r_fault[g] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_a", 32'(w_any[0]), 0);
    chk("reset_b", 32'(w_any[1]), 0);
    chk("reset_c", 32'(w_any[2]), 0);
    r_rst = '0;
    @(negedge clk);

    // Clean reciprocal run on both small instances, extra starts at cycles 5 and 11 (DONE).
    run(3'b011, 2'b00, 16, 5, 11, 0);
    chk("rec_done_cyc_a", d_cyc[0], 11);
    chk("rec_done_num_a", d_num[0], 1);
    chk("rec_ce_cycles_a", ce_cnt[0], 10);
    chk("rec_addr_seq_a", addr_err[0], 0);
    chk("rec_func_a", fn_err[0], 0);
    chk("rec_pass_a", 32'(w_pass[0]), 1);
    chk("rec_cnt_a", 32'(w_cnt[0]), 0);
    chk("rec_ffvld_a", 32'(w_ffvld[0]), 0);
    chk("rec_cfg_a", 32'(w_cfg[0]), 0);
    chk("rec_done_cyc_b", d_cyc[1], 11);
    chk("rec_pass_b", 32'(w_pass[1]), 1);

    // Vectors 3 and 6 corrupted in bit 0; instance 1 ignores that bit.
    r_fault[0] = 1;
    r_fault[1] = 1;
    run(3'b011, 2'b01, 16, 0, 0, 0);
    chk("flt_done_cyc_a", d_cyc[0], 11);
    chk("flt_cnt_a", 32'(w_cnt[0]), 2);
    chk("flt_ffidx_a", 32'(w_ffidx[0]), 3);
    chk("flt_ffvld_a", 32'(w_ffvld[0]), 1);
    chk("flt_pass_a", 32'(w_pass[0]), 0);
    chk("flt_pass_ign_b", 32'(w_pass[1]), 1);
    chk("flt_cnt_ign_b", 32'(w_cnt[1]), 0);
    r_fault[0] = 0;
    r_fault[1] = 0;

    // Reserved function code.
    run(3'b001, 2'b10, 5, 0, 0, 0);
    chk("rsvd_done_cyc", d_cyc[0], 1);
    chk("rsvd_done_num", d_num[0], 1);
    chk("rsvd_ce_cycles", ce_cnt[0], 0);
    chk("rsvd_cfg_err", 32'(w_cfg[0]), 1);
    chk("rsvd_pass", 32'(w_pass[0]), 0);
    chk("rsvd_addr", 32'(w_addr[0]), 0);

    // Full-depth sqrt run with LAT=3.
    run(3'b100, 2'b01, 845, 0, 0, 0);
    chk("sqrt_done_cyc", d_cyc[2], 841);
    chk("sqrt_done_num", d_num[2], 1);
    chk("sqrt_ce_cycles", ce_cnt[2], 840);
    chk("sqrt_addr_seq", addr_err[2], 0);
    chk("sqrt_pass", 32'(w_pass[2]), 1);
    chk("sqrt_cnt", 32'(w_cnt[2]), 0);

    // Every result corrupted: the count equals the number of comparisons made.
    r_fault[2] = 2;
    run(3'b100, 2'b00, 845, 0, 0, 0);
    chk("all_done_cyc", d_cyc[2], 841);
    chk("all_cnt", 32'(w_cnt[2]), 836);
    chk("all_ffidx", 32'(w_ffidx[2]), 0);
    chk("all_pass", 32'(w_pass[2]), 0);
    r_fault[2] = 0;

    // Reset at cycle 400 aborts the run.
    run(3'b100, 2'b01, 410, 0, 0, 400);
    chk("abort_zero", zero_err[2], 0);
    chk("abort_no_done", d_num[2], 0);
    chk("abort_ce_cycles", ce_cnt[2], 400);

    // Fresh isqrt run after the abort.
    run(3'b100, 2'b11, 845, 0, 0, 0);
    chk("isqt_done_cyc", d_cyc[2], 841);
    chk("isqt_func", fn_err[2], 0);
    chk("isqt_pass", 32'(w_pass[2]), 1);
    chk("isqt_cnt", 32'(w_cnt[2]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hybrid_bist.md
# hybrid_bist

On-chip built-in self-test sequencer for the Hybrid reciprocal / square-root / inverse-square-root datapath. It streams input vectors from a test-vector ROM into the datapath, one per cycle. It compares each datapath result against the expected result held in the same ROM word, then reports pass/fail, the mismatch count and the first failing index. Placement: between the vector/expected ROM and the Hybrid unit, in place of the external stimulus driver.

## Interface
- WL, 25: datapath word length (dut_din, dut_dout, expected values).
- DEPTH, 836: number of vectors in the ROM.
- ADDR_W, 10: ROM address width; requires DEPTH <= 2**ADDR_W.
- LAT, 1: Hybrid latency in cycles, from din valid to dout valid with CE high; legal range 1..8.
- IGN_LSB, 0: number of result LSBs excluded from comparison; legal range 0..2.
- CLK  in  1: the single clock, rising edge.
- RST  in  1: synchronous, active-high reset.
- start  in  1: single-cycle request to begin a run; sampled in IDLE only.
- func_sel  in  2: function for the run. 00 is reciprocal, 01 is sqrt, 11 is isqrt, 10 is reserved.
- rom_addr  out  ADDR_W: ROM read address.
- rom_vec  in  WL: input vector, valid the cycle after rom_addr is presented (synchronous ROM).
- rom_exp  in  WL: expected result, same timing as rom_vec.
- dut_CE  out  1: Hybrid clock enable.
- dut_din  out  WL: Hybrid input, equal to rom_vec (combinational pass-through).
- dut_FUNCTION  out  2: Hybrid function select; held constant for the whole run.
- dut_dout  in  WL: Hybrid result.
- busy  out  1: high in RUN and DRAIN.
- done  out  1: one-cycle pulse when a run ends.
- pass  out  1: 1 if the last run had zero mismatches; held until the next accepted start.
- cfg_err  out  1: 1 if the last start used func_sel = 10; held until the next accepted start.
- mismatch_cnt  out  ADDR_W+1: number of mismatches in the current or last run.
- first_fail_idx  out  ADDR_W: index of the first mismatching vector.
- first_fail_vld  out  1: first_fail_idx is meaningful.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1, func_sel legal:
  - Latch func_sel into dut_FUNCTION.
  - Clear mismatch_cnt, pass, cfg_err, first_fail_vld.
  - Set rom_addr=0 and go to RUN.
- IDLE, start=1, func_sel=10: go to DONE with cfg_err=1, pass=0, and no ROM or DUT activity.
- RUN:
  - Present rom_addr each cycle; rom_addr increments by 1 each cycle.
  - After presenting DEPTH-1, go to DRAIN; rom_addr holds at DEPTH-1.
- DRAIN: lasts LAT+1 cycles so all in-flight results are checked, then go to DONE.
- DONE: lasts one cycle. Assert done; pass = (mismatch_cnt==0) && !cfg_err. Return to IDLE.
- Comparison rule: mismatch when dut_dout[WL-1:IGN_LSB] != exp_d[WL-1:IGN_LSB]. exp_d is rom_exp delayed LAT cycles.
- Scoreboard: a delay line of depth LAT carries {valid, expected, index}.
  - valid enters high on cycles where rom_vec is valid from a RUN address.
  - The comparison is applied only when the delay-line output is valid.
- On each mismatch, mismatch_cnt increments; it cannot overflow for DEPTH <= 2**ADDR_W.
- On the first mismatch only, first_fail_idx is loaded with the index and first_fail_vld is set.
- start while busy or in DONE is ignored.
- dut_CE = 1 in RUN and DRAIN; 0 otherwise.

## Timing
- Reset values:
  - State: IDLE.
  - All outputs 0: rom_addr, dut_CE, dut_FUNCTION, busy, done, pass, cfg_err, mismatch_cnt, first_fail_idx, first_fail_vld.
  - Delay-line valids cleared.
- Cycle numbering: start accepted at the edge ending cycle 0.
  - Cycles 1..DEPTH: RUN, with rom_addr = cycle-1.
  - Vector i: reaches dut_din in cycle i+2; its result is compared at the end of cycle i+2+LAT.
  - Cycles DEPTH+1..DEPTH+LAT+1: DRAIN.
  - Cycle DEPTH+LAT+2: DONE, with done=1.
- Status outputs are registered and update on the edge following each comparison. mismatch_cnt is final in the DONE cycle.
- RST asserted mid-run aborts the run. All state returns to reset values at that edge, with no done pulse. The next start begins a fresh run.
- start and RST in the same cycle: RST wins.

## Structure
- Shared package hybrid_pkg holds:
  - Function codes FUNC_REC=2'b00, FUNC_SQRT=2'b01, FUNC_ISQT=2'b11, FUNC_RSVD=2'b10.
  - The bist state encoding.
- Sub-module hybrid_bist_dly: parameterised (LAT, WL+ADDR_W+1 bits) shift line for {valid, expected, index}, cleared by RST.
- The top-level module holds the FSM, the address counter and the result registers.

## Test plan
- Clean run, reciprocal: DEPTH=8, LAT=1, behavioural DUT model exact -> done in cycle 11, pass=1, mismatch_cnt=0, first_fail_vld=0, dut_FUNCTION=00 throughout.
- Injected faults: model corrupts results for vectors 3 and 6 (bit 0 flipped at IGN_LSB=0) -> mismatch_cnt=2, first_fail_idx=3, pass=0. Same faults with IGN_LSB=1 -> pass=1.
- Reserved function: start with func_sel=10 -> done one cycle later, cfg_err=1, pass=0, dut_CE never high, rom_addr stays 0.
- Latency sweep: LAT=3, DEPTH=836, sqrt model -> done in cycle 841, exactly 836 comparisons counted, no comparison on the ROM data present in cycle 1.
- Reset mid-run: RST at cycle 400 -> all outputs 0 in the next cycle, no done pulse. A restart with isqrt (11) completes with pass=1.
- Start while busy: extra start pulses at cycles 5 and DEPTH+LAT+2 -> ignored, single done pulse, counters unaffected.
